// File: rtl/seq_step_monitor_pkg.sv
// Shared state type and legal-sequence rules for the ripple step-counter monitor.
package seq_step_monitor_pkg;

   typedef enum logic {IDLE, TRACK} state_t;

   // Bit n set means value n can appear on the counter: {0,2,5,7,8,9,10,11}.
   localparam logic [15:0] LEGAL_SET = 16'b0000_1111_1010_0101;

   function automatic logic is_legal(input logic [3:0] v);
      return LEGAL_SET[v];
   endfunction

   function automatic logic [3:0] next_value(input logic [3:0] v);
      logic [3:0] nv;
      case (v)
         4'd0:    nv = 4'd2;
         4'd2:    nv = 4'd5;
         4'd5:    nv = 4'd7;
         4'd7:    nv = 4'd8;
         4'd8:    nv = 4'd10;
         4'd10:   nv = 4'd9;
         4'd9:    nv = 4'd11;
         4'd11:   nv = 4'd8;
         default: nv = 4'hF;
      endcase
      return nv;
   endfunction

endpackage

// File: rtl/seq_step_sync.sv
// 2-flop synchronizer and stability filter (SEQ_STEP_MONITOR_FILTER_EN) for the ripple counter.
// Strobe is combinational off the registered samples; no backpressure.
module seq_step_sync #(
   parameter int unsigned STABLE_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] q_in,
   output logic [3:0] val,
   output logic       new_vld
);

`ifdef SEQ_STEP_MONITOR_FILTER_EN
   localparam logic [4:0] THRESH = 5'(STABLE_CYCLES);
`else
   localparam logic [4:0] THRESH = 5'd1;
`endif
   localparam logic [4:0] CAP = 5'(STABLE_CYCLES);

   logic [3:0] s1, s2;
   logic       v1, v2;
   logic [3:0] cand;
   logic [3:0] cnt;
   logic [4:0] run;
   logic [3:0] last;
   logic       have;
   logic       stable;

   // run counts consecutive identical samples including the one now in s2.
   always_comb begin
      run = 5'd1;
      if (s2 == cand)
         run = {1'b0, cnt} + 5'd1;
   end

   assign stable  = v2 && (run >= THRESH);
   assign new_vld = stable && (!have || (s2 != last));
   assign val     = s2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1   <= '0;
         s2   <= '0;
         v1   <= 1'b0;
         v2   <= 1'b0;
         cand <= '0;
         cnt  <= '0;
         last <= '0;
         have <= 1'b0;
      end else begin
         s1 <= q_in;
         s2 <= s1;
         v1 <= 1'b1;
         v2 <= v1;
         if (v2) begin
            cand <= s2;
            cnt  <= (run > CAP) ? CAP[3:0] : run[3:0];
         end
         if (new_vld) begin
            last <= s2;
            have <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_step_monitor.sv
// Tracks the ripple step counter: reports settled values, checks the legal sequence, counts steps/errors.
// Latency 3 edges (2+STABLE_CYCLES with SEQ_STEP_MONITOR_FILTER_EN); no backpressure.
module seq_step_monitor
   import seq_step_monitor_pkg::*;
#(
   parameter int          CNT_W         = 8,
   parameter int unsigned STABLE_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       q_in,
   input  logic             clear,
   output logic [3:0]       value_o,
   output logic             value_valid,
   output logic             locked,
   output logic             seq_err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] step_count,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t     state;
   logic [3:0] sync_val;
   logic       sync_vld;
   logic       legal_new;
   logic       on_seq;
   logic       err_evt;
   logic       step_evt;

   seq_step_sync #(
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .q_in    (q_in),
      .val     (sync_val),
      .new_vld (sync_vld)
   );

   // value_o holds the last accepted value, which is the anchor while tracking.
   assign legal_new = is_legal(sync_val);
   assign on_seq    = (sync_val == next_value(value_o));
   assign err_evt   = sync_vld && ((state == IDLE) ? !legal_new : !on_seq);
   assign step_evt  = sync_vld && (state == TRACK) && on_seq;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         value_o     <= '0;
         value_valid <= 1'b0;
         locked      <= 1'b0;
         seq_err     <= 1'b0;
         err_sticky  <= 1'b0;
         step_count  <= '0;
         err_count   <= '0;
      end else begin
         value_valid <= sync_vld;
         seq_err     <= err_evt;
         locked      <= (state == TRACK);

         if (sync_vld) begin
            value_o <= sync_val;
            if (!legal_new) begin
               state  <= IDLE;
               locked <= 1'b0;
            end else if ((state == IDLE) || on_seq) begin
               state  <= TRACK;
               locked <= 1'b1;
            end else begin
               // Re-anchor on a legal but unexpected value: one cycle unlocked.
               locked <= 1'b0;
            end
         end

         if (clear) begin
            step_count <= '0;
            err_count  <= '0;
            err_sticky <= 1'b0;
         end else begin
            if (step_evt && (step_count != CNT_MAX))
               step_count <= step_count + CNT_ONE;
            if (err_evt) begin
               err_sticky <= 1'b1;
               if (err_count != CNT_MAX)
                  err_count <= err_count + CNT_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_step_monitor.sv
// Directed bench for seq_step_monitor; expectations follow SEQ_STEP_MONITOR_FILTER_EN.
module tb_seq_step_monitor;

`ifdef SEQ_STEP_MONITOR_FILTER_EN
   localparam int LAT     = 5;
   localparam int GL_VV   = 5;
   localparam int GL_STEP = 4;
   localparam int GL_ERR  = 2 * 0;
   localparam int GL_STK  = 0;
`else
   localparam int LAT     = 3;
   localparam int GL_VV   = 7;
   localparam int GL_STEP = 3;
   localparam int GL_ERR  = 2;
   localparam int GL_STK  = 1;
`endif

   logic       clk;
   logic       rst_n;
   logic [3:0] q_in;
   logic       clear;
   logic [3:0] value_o;
   logic       value_valid;
   logic       locked;
   logic       seq_err;
   logic       err_sticky;
   logic [7:0] step_count;
   logic [7:0] err_count;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         vv_n;
   int         err_n;
   int         unlock_n;
   logic [3:0] last_v;

   logic [3:0] seq1 [10] = '{4'd0, 4'd2, 4'd5, 4'd7, 4'd8, 4'd10, 4'd9, 4'd11, 4'd8, 4'd10};

   seq_step_monitor #(
      .CNT_W         (8),
      .STABLE_CYCLES (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .q_in        (q_in),
      .clear       (clear),
      .value_o     (value_o),
      .value_valid (value_valid),
      .locked      (locked),
      .seq_err     (seq_err),
      .err_sticky  (err_sticky),
      .step_count  (step_count),
      .err_count   (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr_mon();
      vv_n     = 0;
      err_n    = 0;
      unlock_n = 0;
      last_v   = 4'd0;
   endtask

   // Drive v right after a rising edge, then watch outputs for n cycles.
   task automatic hold(input logic [3:0] v, input int n);
      @(posedge clk);
      #1 q_in = v;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (value_valid) begin
            vv_n++;
            last_v = value_o;
         end
         if (seq_err) err_n++;
         if (!locked) unlock_n++;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      q_in  = 4'd0;
      clear = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int  lat;
      bit  found;

      rst_n = 1'b0;
      q_in  = 4'd0;
      clear = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_value_o",    32'(value_o),     32'd0);
      check("rst_value_valid", 32'(value_valid), 32'd0);
      check("rst_locked",     32'(locked),      32'd0);
      check("rst_seq_err",    32'(seq_err),     32'd0);
      check("rst_err_sticky", 32'(err_sticky),  32'd0);
      check("rst_step_count", 32'(step_count),  32'd0);
      check("rst_err_count",  32'(err_count),   32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Full legal sequence.
      clr_mon();
      for (int i = 0; i < 10; i++) hold(seq1[i], 10);
      check("seq_valid_pulses", 32'(vv_n),       32'd10);
      check("seq_last_value",   32'(last_v),     32'd10);
      check("seq_step_count",   32'(step_count), 32'd9);
      check("seq_err_count",    32'(err_count),  32'd0);
      check("seq_err_pulses",   32'(err_n),      32'd0);
      check("seq_locked",       32'(locked),     32'd1);

      // Ripple intermediates 6 and 4 for one cycle each between 7 and 8.
      do_reset();
      clr_mon();
      hold(4'd0, 10);
      hold(4'd2, 10);
      hold(4'd5, 10);
      hold(4'd7, 10);
      hold(4'd6, 1);
      hold(4'd4, 1);
      hold(4'd8, 10);
      check("glitch_valid_pulses", 32'(vv_n),       32'(GL_VV));
      check("glitch_step_count",   32'(step_count), 32'(GL_STEP));
      check("glitch_err_count",    32'(err_count),  32'(GL_ERR));
      check("glitch_err_sticky",   32'(err_sticky), 32'(GL_STK));
      check("glitch_locked",       32'(locked),     32'd1);
      check("glitch_value_o",      32'(value_o),    32'd8);

      // Plain clear: statistics only.
      @(posedge clk);
      #1 clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      @(negedge clk);
      check("clear_step_count", 32'(step_count), 32'd0);
      check("clear_err_count",  32'(err_count),  32'd0);
      check("clear_err_sticky", 32'(err_sticky), 32'd0);
      check("clear_locked",     32'(locked),     32'd1);
      check("clear_value_o",    32'(value_o),    32'd8);

      // Legal but unexpected 9 after 8: re-anchor.
      clr_mon();
      hold(4'd9, 10);
      check("reanchor_err_pulses", 32'(err_n),      32'd1);
      check("reanchor_unlock_cyc", 32'(unlock_n),   32'd1);
      check("reanchor_err_count",  32'(err_count),  32'd1);
      check("reanchor_err_sticky", 32'(err_sticky), 32'd1);
      check("reanchor_locked",     32'(locked),     32'd1);
      hold(4'd11, 10);
      check("reanchor_step_after", 32'(step_count), 32'd1);

      // Illegal 13 drops to IDLE; 2 relocks.
      clr_mon();
      hold(4'd13, 10);
      check("illegal_err_pulses", 32'(err_n),     32'd1);
      check("illegal_locked",     32'(locked),    32'd0);
      check("illegal_value_o",    32'(value_o),   32'd13);
      check("illegal_err_count",  32'(err_count), 32'd2);
      hold(4'd2, 10);
      check("relock_locked",     32'(locked),    32'd1);
      check("relock_err_pulses", 32'(err_n),     32'd1);
      check("relock_err_count",  32'(err_count), 32'd2);

      // Drive step_count to saturation.
      hold(4'd5, 6);
      hold(4'd7, 6);
      hold(4'd8, 6);
      for (int k = 0; k < 65; k++) begin
         hold(4'd10, 6);
         hold(4'd9, 6);
         hold(4'd11, 6);
         hold(4'd8, 6);
      end
      check("sat_step_count", 32'(step_count), 32'd255);
      hold(4'd10, 6);
      check("sat_step_hold",  32'(step_count), 32'd255);
      check("sat_err_count",  32'(err_count),  32'd2);

      // Clear coinciding with an illegal-value event.
      @(posedge clk);
      #1 q_in = 4'd13;
      repeat (LAT - 1) @(posedge clk);
      #1 clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      @(negedge clk);
      check("clrerr_seq_err",     32'(seq_err),     32'd1);
      check("clrerr_value_valid", 32'(value_valid), 32'd1);
      check("clrerr_err_count",   32'(err_count),   32'd0);
      check("clrerr_err_sticky",  32'(err_sticky),  32'd0);
      check("clrerr_step_count",  32'(step_count),  32'd0);
      @(negedge clk);
      check("clrerr_seq_err_end", 32'(seq_err),     32'd0);

      // Mid-sequence reset at value 10.
      hold(4'd10, 10);
      check("prerst_locked", 32'(locked), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("midrst_value_o",    32'(value_o),     32'd0);
      check("midrst_valid",      32'(value_valid), 32'd0);
      check("midrst_locked",     32'(locked),      32'd0);
      check("midrst_step_count", 32'(step_count),  32'd0);
      lat   = 0;
      found = 1'b0;
      for (int i = 1; i <= 20 && !found; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (value_valid) begin
            found = 1'b1;
            lat   = i;
         end
      end
      check("midrst_latency", 32'(lat),     32'(LAT));
      check("midrst_locked2", 32'(locked),  32'd1);
      check("midrst_value2",  32'(value_o), 32'd10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_step_monitor.md
# seq_step_monitor

Downstream consumer of the 4-bit ripple (asynchronous) step counter that produces the sequence 0, 2, 5, 7, 8, 10, 9, 11, 8, ... The block samples the counter output into the system clock domain, suppresses ripple glitches, and reports each new settled value. It also checks every transition against the legal sequence, and tracks lock status, error events and step counts for the bench and for status logic.

## Interface
Parameters:
- CNT_W, 8, width of step and error counters
- STABLE_CYCLES, 3, consecutive equal synchronized samples required before a value is accepted (1..15; used only with filter compiled in)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- q_in  input  4  ripple counter output {q3,q2,q1,q0}, asynchronous to clk
- clear  input  1  synchronous clear of statistics
- value_o  output  4  last accepted settled value
- value_valid  output  1  one-cycle pulse: value_o updated with a new value
- locked  output  1  high while tracking a legal sequence
- seq_err  output  1  one-cycle pulse on illegal value or illegal transition
- err_sticky  output  1  set by any seq_err, cleared by clear/reset
- step_count  output  CNT_W  legal transitions observed, saturating
- err_count  output  CNT_W  seq_err events, saturating

## Operation
- Legal next-value map: 0→2, 2→5, 5→7, 7→8, 8→10, 10→9, 9→11, 11→8. The legal set is {0,2,5,7,8,9,10,11}; all other values are illegal.
- Input path: 2-flop synchronizer per bit, then the stability filter (see Configuration).
- Accept event: the filtered value differs from the previously accepted value, or no value has been accepted since reset. Equal consecutive values are not events.
- FSM states:
  - IDLE: locked=0. On an accept event, a legal value moves to TRACK. An illegal value pulses seq_err and stays in IDLE.
  - TRACK: locked=1. On an accept event that matches the expected next value, increment step_count and stay in TRACK.
  - TRACK mismatch, new value legal: pulse seq_err and stay in TRACK, re-anchored on the new value. locked drops low for exactly one cycle.
  - TRACK mismatch, new value illegal: pulse seq_err and go to IDLE.
- value_o and value_valid update on every accept event, legal or not.
- Counters saturate at all-ones and never wrap.
- clear: zeroes step_count, err_count and err_sticky. It does not affect FSM, value_o or the synchronizer. If clear coincides with an event, clear wins for the counters and err_sticky, and seq_err still pulses.

## Timing
- Reset (rst_n low at a rising edge): value_o=0, value_valid=0, locked=0, seq_err=0, err_sticky=0, step_count=0, err_count=0. Synchronizer and filter registers go to 0, the "accepted" flag is cleared, and the FSM goes to IDLE.
- Reset mid-operation discards any in-flight sample. After reset, the first stable value is always an accept event, including 0.
- Latency from a q_in change to value_valid:
  - filter compiled in: 2+STABLE_CYCLES rising edges after the first sampling edge.
  - filter compiled out: 3 edges.
- seq_err, locked, the step_count increment and err_count increment are all registered in the same cycle as value_valid.
- Minimum spacing between accept events is 1 cycle. There is no backpressure.

## Configuration
- SEQ_STEP_MONITOR_FILTER_EN defined: a candidate is accepted only after STABLE_CYCLES consecutive identical synchronized samples. Any differing sample restarts the count with the new candidate. Ripple intermediates (e.g. 7→6→4→0→8) shorter than STABLE_CYCLES are never reported.
- Not defined: every change of the synchronized value is an accept event. Ripple intermediates are reported and will raise seq_err. STABLE_CYCLES is ignored.

## Structure
- Package seq_step_monitor_pkg:
  - FSM state enum (IDLE, TRACK).
  - legal-set constant.
  - next-value function (4-bit in, 4-bit expected out).
  - is_legal function.
- Sub-module seq_step_sync: 2-flop synchronizer plus optional stability filter. Outputs the settled value and a one-cycle new-value strobe.

## Test plan
- Reset, then drive q_in 0,2,5,7,8,10,9,11,8,10, each held 10 cycles → 10 value_valid pulses, locked=1 from the first, step_count=9, err_count=0.
- Filter on, STABLE_CYCLES=3; drive 7, then 6 and 4 each for 1 cycle, then 8 → no report of 6 or 4, step 7→8 counted, no seq_err.
- In TRACK at 8, drive 9 → seq_err pulse, err_count=1, err_sticky=1, locked low one cycle then high. Then drive 11 → step_count increments.
- Drive illegal 13 while in TRACK → seq_err, FSM to IDLE, locked=0. Then drive 2 → locked=1, no error.
- Hold step_count at all-ones, apply a legal step → stays all-ones. Assert clear in the same cycle as an error → err_count=0, err_sticky=0, seq_err pulses.
- Assert rst_n low for 1 cycle mid-sequence at value 10 → all outputs 0. Then with q_in held at 10 → value_valid after 2+STABLE_CYCLES edges, locked=1.
